rtc_calendar_core: RTL
======================

// Module: rtc_calendar_core
// PURPOSE
//  Parametrised real-time clock/calendar core: second, minute, hour, day, month and year counters in BCD,
//  driven by a prescaler off the board clock. Adds leap-year handling, a valid/ready field-set port with
//  range checking, a run/hold control and 12/24-hour display mode. Feeds the seven-segment decoders in the
//  clock top level; the core itself contains no segment logic.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  input clock frequency; prescaler terminal count = CLK_FREQ_HZ-1 (>=2)
//  YEAR_RESET   16'h2000    BCD year loaded at reset
// PORTS
//  built_in_clk  in   1   system clock; one clock domain only
//  glob_rst      in   1   reset, asynchronous, active-high
//  run           in   1   1 = prescaler counts; 0 = time frozen, prescaler holds its value
//  mode_12h      in   1   1 = hour_bcd/pm in 12-hour format; 0 = 24-hour format
//  set_valid     in   1   set request
//  set_ready     out  1   core can accept a set this cycle
//  set_field     in   3   0 sec, 1 min, 2 hour, 3 day, 4 mon, 5 year; 6,7 reserved (invalid)
//  set_value     in   16  BCD value; sec/min/hour/day/mon use [7:0], [15:8] ignored; year uses all 16
//  set_err       out  1   one-cycle pulse: last accepted set was rejected
//  sec_pulse     out  1   one-cycle pulse on each seconds increment
//  sec_bcd / min_bcd / day_bcd / mon_bcd  out 8  BCD fields
//  hour_bcd      out  8   BCD hour, format per mode_12h
//  pm            out  1   12-hour mode: 1 = hour >= 12; forced 0 in 24-hour mode
//  year_bcd      out  16  BCD year 0000-9999
// BEHAVIOUR
//  Reset (async, glob_rst=1): prescaler 0, time 00:00:00, date 01/01/YEAR_RESET, set_err=0, sec_pulse=0.
//  Prescaler: counts 0..CLK_FREQ_HZ-1 while run=1; tick = (count==CLK_FREQ_HZ-1) & run; wraps to 0.
//  On tick: sec+1; carries ripple in the SAME cycle: sec 59->00 carries min, min 59->00 carries hour,
//   hour 23->00 carries day, day==days_in_month -> 01 carries mon, mon 12->01 carries year, 9999->0000.
//   sec_pulse registered, high the cycle after tick, together with the updated fields.
//  days_in_month: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; feb 29 if leap else 28.
//  Leap (on BCD): low pair YY%4==0 and YY!=00, or YY==00 and high pair CC%4==0. 2024,2000 leap; 2100 not.
//   BCD pair %4==0: tens even & ones in {0,4,8}, or tens odd & ones in {2,6}.
//  Set handshake: set_ready = ~tick (deasserted only on the tick cycle); accept = set_valid & set_ready.
//   Accepted valid set: field written, visible at outputs next cycle; set_err stays 0.
//   Writing sec also clears prescaler to 0 (next second starts full-length).
//   Validity: every nibble <=9; sec,min 00-59; hour 00-23 (always 24h encoding); mon 01-12;
//   day 01..days_in_month(current mon, current year); year any BCD; set_field 6/7 invalid.
//   Invalid: no state change, set_err=1 the next cycle for one cycle.
//   Writing mon or year: if current day > new days_in_month, day clamps to that value in the same cycle.
//  Display: mode_12h=1: hour 00->12 pm=0, 01-11 unchanged pm=0, 12 -> 12 pm=1, 13-23 -> 01-11 pm=1.
//   Combinational from registered hour and mode_12h; internal hour always 24h.
//  run=0: no ticks, sets still accepted, set_ready=1. Reset mid-second: prescaler restarts from 0.
// STRUCTURE
//  Shared include rtc_defs.vh: field codes (FLD_SEC..FLD_YEAR), BCD limits (59, 23, 12), month-length
//   constants, function bcd_pair_div4.
//  Sub-module rtc_prescaler (params CLK_FREQ_HZ; ports built_in_clk, glob_rst, run, clr, tick).
//  Field counters, leap/days logic, set validation and 12h mapping stay in this module.
// TESTING (bench overrides CLK_FREQ_HZ=4, run=1)
//  1 Release reset -> 00:00:00 01/01/2000; after 4 clocks sec_bcd=01, one sec_pulse; pulses every 4 clocks.
//  2 Set 23:59:59 31/12/1999 -> next tick gives 00:00:00 01/01/2000, all fields update in one cycle.
//  3 Set 23:59:59 28/02 for 2024 -> 29/02; 2100 -> 01/03; 2000 -> 29/02; then 29/02/2024 -> 01/03.
//  4 Set min=8'h60, hour=8'h24, sec=8'h5A, field=6, day=31 with mon=04 -> set_err pulse, fields unchanged.
//  5 Day=31 mon=01, set mon=02 year 2023 -> day=28; set_valid on tick cycle -> set_ready=0, accepted next.
//  6 mode_12h=1: hour 00 -> 12 pm=0; 13 -> 01 pm=1; run=0 freezes time; glob_rst mid-second -> reset values.

Source files
------------

// File: rtl/rtc_calendar_core_pkg.sv
// rtc_calendar_core_pkg: field codes, BCD limits and calendar helpers for the RTC core
package rtc_calendar_core_pkg;
   localparam logic [2:0] FLD_SEC  = 3'd0;
   localparam logic [2:0] FLD_MIN  = 3'd1;
   localparam logic [2:0] FLD_HOUR = 3'd2;
   localparam logic [2:0] FLD_DAY  = 3'd3;
   localparam logic [2:0] FLD_MON  = 3'd4;
   localparam logic [2:0] FLD_YEAR = 3'd5;
   localparam logic [7:0] BCD_59 = 8'h59;
   localparam logic [7:0] BCD_23 = 8'h23;
   localparam logic [7:0] BCD_12 = 8'h12;
   localparam logic [7:0] DAYS_LONG     = 8'h31;
   localparam logic [7:0] DAYS_SHORT    = 8'h30;
   localparam logic [7:0] DAYS_FEB_LEAP = 8'h29;
   localparam logic [7:0] DAYS_FEB      = 8'h28;

   // odd tens shift the residue by 2, so the legal ones digits swap between {0,4,8} and {2,6}
   function automatic logic bcd_pair_div4(input logic [7:0] p);
      return p[4] ? (p[3:0] == 4'h2 || p[3:0] == 4'h6)
                  : (p[3:0] == 4'h0 || p[3:0] == 4'h4 || p[3:0] == 4'h8);
   endfunction

   function automatic logic is_leap(input logic [15:0] y);
      return (y[7:0] != 8'h00) ? bcd_pair_div4(y[7:0]) : bcd_pair_div4(y[15:8]);
   endfunction

   function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [15:0] y);
      return (m == 8'h02) ? (is_leap(y) ? DAYS_FEB_LEAP : DAYS_FEB) :
             (m == 8'h04 || m == 8'h06 || m == 8'h09 || m == 8'h11) ? DAYS_SHORT : DAYS_LONG;
   endfunction

   function automatic logic bcd_ok(input logic [15:0] v);
      return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v[11:8] <= 4'd9 && v[15:12] <= 4'd9;
   endfunction

   function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
      return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++)
         if (c) begin
            c = (r[4*i +: 4] == 4'd9);
            r[4*i +: 4] = c ? 4'd0 : r[4*i +: 4] + 4'd1;
         end
      return r;
   endfunction

   function automatic logic [7:0] hour_12(input logic [7:0] h);
      logic [4:0] b;
      b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
      b = (b == 5'd0) ? 5'd12 : (b > 5'd12) ? b - 5'd12 : b;
      return (b >= 5'd10) ? {4'h1, 4'(b - 5'd10)} : {4'h0, b[3:0]};
   endfunction
endpackage

// File: rtl/rtc_calendar_core_prescaler.sv
// rtc_calendar_core_prescaler: divides the board clock down to a one-cycle seconds tick
module rtc_calendar_core_prescaler #(
   parameter int CLK_FREQ_HZ = 50_000_000
) (
   input  logic i_built_in_clk,
   input  logic i_glob_rst,
   input  logic i_run,
   input  logic i_clr,
   output logic o_tick
);
   localparam int W = $clog2(CLK_FREQ_HZ);
   localparam logic [W-1:0] TC = W'(CLK_FREQ_HZ - 1);

   logic [W-1:0] r_cnt;

   assign o_tick = i_run & (r_cnt == TC);

   always_ff @(posedge i_built_in_clk or posedge i_glob_rst)
      if (i_glob_rst) r_cnt <= '0;
      else r_cnt <= (i_clr | o_tick) ? '0 : i_run ? r_cnt + W'(1) : r_cnt;
endmodule

// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: BCD time/date counters with leap years, range-checked field set and 12/24h display
module rtc_calendar_core
   import rtc_calendar_core_pkg::*;
#(
   parameter int          CLK_FREQ_HZ = 50_000_000,
   parameter logic [15:0] YEAR_RESET  = 16'h2000
) (
   input  logic        i_built_in_clk,
   input  logic        i_glob_rst,
   input  logic        i_run,
   input  logic        i_mode_12h,
   input  logic        i_set_valid,
   output logic        o_set_ready,
   input  logic [2:0]  i_set_field,
   input  logic [15:0] i_set_value,
   output logic        o_set_err,
   output logic        o_sec_pulse,
   output logic [7:0]  o_sec_bcd,
   output logic [7:0]  o_min_bcd,
   output logic [7:0]  o_hour_bcd,
   output logic [7:0]  o_day_bcd,
   output logic [7:0]  o_mon_bcd,
   output logic        o_pm,
   output logic [15:0] o_year_bcd
);
   logic [7:0]  r_sec, r_min, r_hour, r_day, r_mon;
   logic [15:0] r_year;
   logic        r_set_err, r_sec_pulse;
   logic        w_tick, w_c_min, w_c_hour, w_c_day, w_c_mon, w_c_year;
   logic        w_accept, w_valid, w_range, w_wr;
   logic [7:0]  w_v8, w_dim, w_dim_new;

   rtc_calendar_core_prescaler #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_prescaler (
      .i_built_in_clk(i_built_in_clk),
      .i_glob_rst    (i_glob_rst),
      .i_run         (i_run),
      .i_clr         (w_wr && i_set_field == FLD_SEC),
      .o_tick        (w_tick)
   );

   assign w_dim    = days_in_month(r_mon, r_year);
   assign w_c_min  = w_tick & (r_sec == BCD_59);
   assign w_c_hour = w_c_min & (r_min == BCD_59);
   assign w_c_day  = w_c_hour & (r_hour == BCD_23);
   assign w_c_mon  = w_c_day & (r_day == w_dim);
   assign w_c_year = w_c_mon & (r_mon == BCD_12);

   assign w_v8      = i_set_value[7:0];
   // month length as it will be after a mon/year write, used to clamp the day
   assign w_dim_new = days_in_month(i_set_field == FLD_MON ? w_v8 : r_mon,
                                    i_set_field == FLD_YEAR ? i_set_value : r_year);
   assign w_range   = (i_set_field == FLD_SEC || i_set_field == FLD_MIN) ? w_v8 <= BCD_59 :
                      (i_set_field == FLD_HOUR) ? w_v8 <= BCD_23 :
                      (i_set_field == FLD_DAY)  ? w_v8 != 8'h00 && w_v8 <= w_dim :
                      (i_set_field == FLD_MON)  ? w_v8 != 8'h00 && w_v8 <= BCD_12 :
                      (i_set_field == FLD_YEAR);
   assign w_valid   = w_range & bcd_ok(i_set_field == FLD_YEAR ? i_set_value : {8'h00, w_v8});
   assign o_set_ready = ~w_tick;
   assign w_accept  = i_set_valid & o_set_ready;
   assign w_wr      = w_accept & w_valid;

   always_ff @(posedge i_built_in_clk or posedge i_glob_rst)
      if (i_glob_rst) begin
         r_sec       <= 8'h00;
         r_min       <= 8'h00;
         r_hour      <= 8'h00;
         r_day       <= 8'h01;
         r_mon       <= 8'h01;
         r_year      <= YEAR_RESET;
         r_set_err   <= 1'b0;
         r_sec_pulse <= 1'b0;
      end else begin
         r_sec_pulse <= w_tick;
         r_set_err   <= w_accept & ~w_valid;
         if (w_tick) begin
            r_sec <= w_c_min ? 8'h00 : bcd_inc8(r_sec);
            if (w_c_min) r_min <= w_c_hour ? 8'h00 : bcd_inc8(r_min);
            if (w_c_hour) r_hour <= w_c_day ? 8'h00 : bcd_inc8(r_hour);
            if (w_c_day) r_day <= w_c_mon ? 8'h01 : bcd_inc8(r_day);
            if (w_c_mon) r_mon <= w_c_year ? 8'h01 : bcd_inc8(r_mon);
            if (w_c_year) r_year <= bcd_inc16(r_year);
         end else if (w_wr) begin
            if (i_set_field == FLD_SEC) r_sec <= w_v8;
            if (i_set_field == FLD_MIN) r_min <= w_v8;
            if (i_set_field == FLD_HOUR) r_hour <= w_v8;
            if (i_set_field == FLD_DAY) r_day <= w_v8;
            if (i_set_field == FLD_MON) r_mon <= w_v8;
            if (i_set_field == FLD_YEAR) r_year <= i_set_value;
            if ((i_set_field == FLD_MON || i_set_field == FLD_YEAR) && r_day > w_dim_new)
               r_day <= w_dim_new;
         end
      end

   assign o_sec_bcd   = r_sec;
   assign o_min_bcd   = r_min;
   assign o_hour_bcd  = i_mode_12h ? hour_12(r_hour) : r_hour;
   assign o_pm        = i_mode_12h & (r_hour >= BCD_12);
   assign o_day_bcd   = r_day;
   assign o_mon_bcd   = r_mon;
   assign o_year_bcd  = r_year;
   assign o_set_err   = r_set_err;
   assign o_sec_pulse = r_sec_pulse;
endmodule
